cart_audio_mixer: RTL

Time-multiplexed stereo mixer that consumes the cartridge-side audio outputs (POKEY, YM2151, Covox) plus the console TIA mono audio and produces one saturated signed 16-bit stereo sample per `sample_ce` strobe. It sits directly downstream of the cart block and feeds the core's audio output path. Per-source gain, an optional one-pole low-pass and an overrun flag are included.

---
 rtl/cart_audio_mixer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/cart_audio_mixer.sv
// Purpose: time-multiplexed stereo mixer for TIA/POKEY/YM/Covox with per-source gain, saturation and optional one-pole LPF.
// Latency: 6 clk_sys edges from an accepted sample_ce to updated audio_l/audio_r; sample_valid is high for the cycle after.
// Backpressure: none; sample_ce arriving while a mix is in flight is dropped and sets the sticky overrun flag.
module cart_audio_mixer #(
  parameter int ACC_W     = 20,
  parameter int LPF_SHIFT = 2
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               sample_ce,
  input  logic [15:0]        tia_audio,
  input  logic [15:0]        pokey_audio_l,
  input  logic [15:0]        pokey_audio_r,
  input  logic [15:0]        ym_audio_l,
  input  logic [15:0]        ym_audio_r,
  input  logic [15:0]        covox_l,
  input  logic [15:0]        covox_r,
  input  logic [7:0]         gain,
  input  logic               lpf_en,
  output logic signed [15:0] audio_l,
  output logic signed [15:0] audio_r,
  output logic               sample_valid,
  output logic               overrun
);

  typedef enum logic [2:0] {IDLE, SRC0, SRC1, SRC2, SRC3, SAT, FILT} state_t;

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-32768);

  state_t state, state_nx;

  // Snapshot registers; unsigned sources keep only bits [15:1] since they are halved anyway.
  logic [14:0]        tia_q, pokey_l_q, pokey_r_q, covox_l_q, covox_r_q;
  logic signed [15:0] ym_l_q, ym_r_q;
  logic [7:0]         gain_q;
  logic               lpf_q;

  logic signed [ACC_W-1:0] acc_l, acc_r, term_l, term_r;
  logic signed [15:0]      sat_l, sat_r;
  logic signed [16:0]      diff_l, diff_r, step_l, step_r, sum_l, sum_r;

  // Sign-extend to accumulator width, then apply the 2-bit gain code as a shift.
  function automatic logic signed [ACC_W-1:0] scale(input logic signed [15:0] v, input logic [1:0] g);
    logic signed [ACC_W-1:0] ext;
    ext = {{(ACC_W-16){v[15]}}, v};
    case (g)
      2'd0:    scale = '0;
      2'd1:    scale = ext >>> 2;
      2'd2:    scale = ext >>> 1;
      default: scale = ext;
    endcase
  endfunction

  // Unsigned 16-bit sample mapped onto 0..32767.
  function automatic logic signed [15:0] uns(input logic [14:0] x);
    uns = {1'b0, x};
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] a);
    if (a > MAX_V)      sat16 = 16'sh7FFF;
    else if (a < MIN_V) sat16 = 16'sh8000;
    else                sat16 = a[15:0];
  endfunction

  // Bits of inputs and intermediate sums that are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{tia_audio[0], pokey_audio_l[0], pokey_audio_r[0],
                         covox_l[0], covox_r[0], sum_l[16], sum_r[16]};

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state: fixed walk through the four sources, saturate, filter.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample_ce) state_nx = SRC0;
      SRC0:    state_nx = SRC1;
      SRC1:    state_nx = SRC2;
      SRC2:    state_nx = SRC3;
      SRC3:    state_nx = SAT;
      SAT:     state_nx = FILT;
      FILT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Select the gain-scaled term for the source addressed by the current state.
  always_comb begin
    term_l = '0;
    term_r = '0;
    case (state)
      SRC0: begin
        term_l = scale(uns(tia_q), gain_q[1:0]);
        term_r = term_l;
      end
      SRC1: begin
        term_l = scale(uns(pokey_l_q), gain_q[3:2]);
        term_r = scale(uns(pokey_r_q), gain_q[3:2]);
      end
      SRC2: begin
        term_l = scale(ym_l_q, gain_q[5:4]);
        term_r = scale(ym_r_q, gain_q[5:4]);
      end
      SRC3: begin
        term_l = scale(uns(covox_l_q), gain_q[7:6]);
        term_r = scale(uns(covox_r_q), gain_q[7:6]);
      end
      default: ;
    endcase
  end

  // One-pole filter step at 17 bits; the result always lies between y and sat so it fits 16 bits.
  always_comb begin
    diff_l = {sat_l[15], sat_l} - {audio_l[15], audio_l};
    diff_r = {sat_r[15], sat_r} - {audio_r[15], audio_r};
    step_l = diff_l >>> LPF_SHIFT;
    step_r = diff_r >>> LPF_SHIFT;
    sum_l  = {audio_l[15], audio_l} + step_l;
    sum_r  = {audio_r[15], audio_r} + step_r;
  end

  // Datapath: snapshot, accumulate, saturate, filter/output, overrun tracking.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tia_q        <= '0;
      pokey_l_q    <= '0;
      pokey_r_q    <= '0;
      ym_l_q       <= '0;
      ym_r_q       <= '0;
      covox_l_q    <= '0;
      covox_r_q    <= '0;
      gain_q       <= '0;
      lpf_q        <= 1'b0;
      acc_l        <= '0;
      acc_r        <= '0;
      sat_l        <= '0;
      sat_r        <= '0;
      audio_l      <= '0;
      audio_r      <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (sample_ce && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_ce) begin
            tia_q     <= tia_audio[15:1];
            pokey_l_q <= pokey_audio_l[15:1];
            pokey_r_q <= pokey_audio_r[15:1];
            ym_l_q    <= ym_audio_l;
            ym_r_q    <= ym_audio_r;
            covox_l_q <= covox_l[15:1];
            covox_r_q <= covox_r[15:1];
            gain_q    <= gain;
            lpf_q     <= lpf_en;
            acc_l     <= '0;
            acc_r     <= '0;
          end
        end
        SRC0, SRC1, SRC2, SRC3: begin
          acc_l <= acc_l + term_l;
          acc_r <= acc_r + term_r;
        end
        SAT: begin
          sat_l <= sat16(acc_l);
          sat_r <= sat16(acc_r);
        end
        FILT: begin
          audio_l      <= lpf_q ? sum_l[15:0] : sat_l;
          audio_r      <= lpf_q ? sum_r[15:0] : sat_r;
          sample_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
